// File: rtl/fp16_to_int32_conv.sv
// rtl/fp16_to_int32_conv.sv - pipelined FP16 to INT32 converter with invalid/inexact flags
// Input register, decode/align stage, then round/sign/saturate into the output registers.
module fp16_to_int32_conv #(
  parameter int          ROUND_MODE = 0,
  parameter logic [31:0] NAN_VALUE  = 32'h7FFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        input_valid,
  input  logic [15:0] data_i,
  output logic [31:0] data_o,
  output logic        output_update,
  output logic        flag_invalid,
  output logic        flag_inexact
);

  logic        in_valid_q, in_valid_d;
  logic [15:0] in_data_q, in_data_d;

  logic        s1_valid_q, s1_valid_d;
  logic        s1_sign_q, s1_sign_d;
  logic        s1_inf_q, s1_inf_d;
  logic        s1_nan_q, s1_nan_d;
  logic [31:0] s1_mag_q, s1_mag_d;
  logic        s1_guard_q, s1_guard_d;
  logic        s1_sticky_q, s1_sticky_d;

  logic        upd_q, upd_d;
  logic [31:0] data_q, data_d;
  logic        inv_q, inv_d;
  logic        inx_q, inx_d;

  logic [4:0]  exp_f;
  logic [9:0]  man_f;
  logic [10:0] sig;
  logic [4:0]  lsh;
  logic [4:0]  rsh;
  logic [21:0] ext;

  logic        inc;
  logic [31:0] mag_r;

  always_comb begin
    in_valid_d = input_valid;
    in_data_d  = data_i;
  end

  // Right shift keeps 11 fraction bits below the integer part: bit 10 is guard, bits 9:0 feed sticky.
  always_comb begin
    exp_f = in_data_q[14:10];
    man_f = in_data_q[9:0];
    sig   = {(exp_f != 5'd0), man_f};
    lsh   = exp_f - 5'd25;
    rsh   = (exp_f == 5'd0) ? 5'd24 : (5'd25 - exp_f);
    ext   = {sig, 11'b0} >> rsh;

    s1_valid_d  = in_valid_q;
    s1_sign_d   = in_data_q[15];
    s1_inf_d    = (exp_f == 5'd31) && (man_f == 10'd0);
    s1_nan_d    = (exp_f == 5'd31) && (man_f != 10'd0);
    s1_mag_d    = 32'd0;
    s1_guard_d  = 1'b0;
    s1_sticky_d = 1'b0;

    if (exp_f >= 5'd25) begin
      s1_mag_d = {21'b0, sig} << lsh;
    end else if (rsh >= 5'd12) begin
      s1_sticky_d = |sig;
    end else begin
      s1_mag_d    = {21'b0, ext[21:11]};
      s1_guard_d  = ext[10];
      s1_sticky_d = |ext[9:0];
    end
  end

  always_comb begin
    inc    = (ROUND_MODE == 0) && s1_guard_q && (s1_sticky_q || s1_mag_q[0]);
    mag_r  = s1_mag_q + {31'b0, inc};

    upd_d  = s1_valid_q;
    data_d = data_q;
    inv_d  = inv_q;
    inx_d  = inx_q;

    if (s1_valid_q) begin
      if (s1_nan_q) begin
        data_d = NAN_VALUE;
        inv_d  = 1'b1;
        inx_d  = 1'b0;
      end else if (s1_inf_q) begin
        data_d = s1_sign_q ? 32'h80000000 : 32'h7FFFFFFF;
        inv_d  = 1'b1;
        inx_d  = 1'b0;
      end else begin
        // Negating a zero magnitude yields zero, so -0 needs no special case.
        data_d = s1_sign_q ? (32'd0 - mag_r) : mag_r;
        inv_d  = 1'b0;
        inx_d  = s1_guard_q | s1_sticky_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q  <= 1'b0;
      in_data_q   <= 16'd0;
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_nan_q    <= 1'b0;
      s1_mag_q    <= 32'd0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      upd_q       <= 1'b0;
      data_q      <= 32'd0;
      inv_q       <= 1'b0;
      inx_q       <= 1'b0;
    end else begin
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_inf_q    <= s1_inf_d;
      s1_nan_q    <= s1_nan_d;
      s1_mag_q    <= s1_mag_d;
      s1_guard_q  <= s1_guard_d;
      s1_sticky_q <= s1_sticky_d;
      upd_q       <= upd_d;
      data_q      <= data_d;
      inv_q       <= inv_d;
      inx_q       <= inx_d;
    end
  end

  assign data_o        = data_q;
  assign output_update = upd_q;
  assign flag_invalid  = inv_q;
  assign flag_inexact  = inx_q;

endmodule

// File: tb/tb_fp16_to_int32_conv.sv
// tb/tb_fp16_to_int32_conv.sv - directed bench for fp16_to_int32_conv
// Two instances share inputs: round-to-nearest-even with default NaN value, and truncate with a custom one.
module tb_fp16_to_int32_conv;

  localparam logic [31:0] NAN1 = 32'h12345678;

  logic        clk;
  logic        rst;
  logic        input_valid;
  logic [15:0] data_i;
  logic [31:0] d0, d1;
  logic        u0, u1, inv0, inv1, inx0, inx1;

  int total = 0;
  int bad   = 0;

  fp16_to_int32_conv #(.ROUND_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .input_valid(input_valid), .data_i(data_i),
    .data_o(d0), .output_update(u0), .flag_invalid(inv0), .flag_inexact(inx0)
  );

  fp16_to_int32_conv #(.ROUND_MODE(1), .NAN_VALUE(NAN1)) dut1 (
    .clk(clk), .rst(rst), .input_valid(input_valid), .data_i(data_i),
    .data_o(d1), .output_update(u1), .flag_invalid(inv1), .flag_inexact(inx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic inx, input logic inv);
    chk({tag, " upd0"}, {31'b0, u0}, 32'd1);
    chk({tag, " upd1"}, {31'b0, u1}, 32'd1);
    chk({tag, " data0"}, d0, e0);
    chk({tag, " data1"}, d1, e1);
    chk({tag, " inx0"}, {31'b0, inx0}, {31'b0, inx});
    chk({tag, " inx1"}, {31'b0, inx1}, {31'b0, inx});
    chk({tag, " inv0"}, {31'b0, inv0}, {31'b0, inv});
    chk({tag, " inv1"}, {31'b0, inv1}, {31'b0, inv});
  endtask

  // One isolated request: no pulse after two edges, pulse after the third.
  task automatic single(input string tag, input logic [15:0] v, input logic [31:0] e0,
                        input logic [31:0] e1, input logic inx, input logic inv);
    input_valid = 1'b1;
    data_i      = v;
    tick();
    input_valid = 1'b0;
    data_i      = 16'hFFFF;
    tick();
    chk({tag, " early"}, {31'b0, u0}, 32'd0);
    tick();
    chk_out(tag, e0, e1, inx, inv);
  endtask

  initial begin
    rst         = 1'b1;
    input_valid = 1'b0;
    data_i      = 16'd0;
    tick();
    tick();
    input_valid = 1'b1;
    data_i      = 16'h7555;
    tick();
    chk("rst data", d0, 32'd0);
    chk("rst upd", {31'b0, u0}, 32'd0);
    chk("rst flags", {30'b0, inv0, inx0}, 32'd0);
    rst         = 1'b0;
    input_valid = 1'b0;
    tick();
    chk("post rst upd", {31'b0, u0}, 32'd0);
    tick();
    tick();
    chk("post rst upd late", {31'b0, u0}, 32'd0);

    single("basic 7555", 16'h7555, 32'h00005550, 32'h00005550, 1'b0, 1'b0);
    tick();
    chk("hold upd", {31'b0, u0}, 32'd0);
    chk("hold data", d0, 32'h00005550);

    single("tie 4100", 16'h4100, 32'd2, 32'd2, 1'b1, 1'b0);
    single("half 3800", 16'h3800, 32'd0, 32'd0, 1'b1, 1'b0);
    single("1.5 3E00", 16'h3E00, 32'd2, 32'd1, 1'b1, 1'b0);
    single("near1 3BFF", 16'h3BFF, 32'd1, 32'd0, 1'b1, 1'b0);
    single("quarter 3400", 16'h3400, 32'd0, 32'd0, 1'b1, 1'b0);
    single("e10 6400", 16'h6400, 32'd1024, 32'd1024, 1'b0, 1'b0);
    single("max 7BFF", 16'h7BFF, 32'h0000FFE0, 32'h0000FFE0, 1'b0, 1'b0);
    single("min FBFF", 16'hFBFF, 32'hFFFF0020, 32'hFFFF0020, 1'b0, 1'b0);
    single("-inf", 16'hFC00, 32'h80000000, 32'h80000000, 1'b0, 1'b1);
    single("+inf", 16'h7C00, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1);
    single("nan", 16'h7E01, 32'h7FFFFFFF, NAN1, 1'b0, 1'b1);
    single("-0", 16'h8000, 32'd0, 32'd0, 1'b0, 1'b0);
    single("subn", 16'h0001, 32'd0, 32'd0, 1'b1, 1'b0);

    input_valid = 1'b1;
    data_i      = 16'h7388;
    tick();
    data_i      = 16'hC100;
    tick();
    data_i      = 16'h3E00;
    tick();
    input_valid = 1'b0;
    chk_out("stream0", 32'h00003C40, 32'h00003C40, 1'b0, 1'b0);
    tick();
    chk_out("stream1", 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1, 1'b0);
    tick();
    chk_out("stream2", 32'd2, 32'd1, 1'b1, 1'b0);
    tick();
    chk("stream end upd", {31'b0, u0}, 32'd0);

    input_valid = 1'b1;
    data_i      = 16'h7555;
    tick();
    input_valid = 1'b0;
    data_i      = 16'h7C00;
    tick();
    input_valid = 1'b1;
    data_i      = 16'h7388;
    tick();
    input_valid = 1'b0;
    chk_out("bubble a", 32'h00005550, 32'h00005550, 1'b0, 1'b0);
    tick();
    chk("bubble gap upd", {31'b0, u0}, 32'd0);
    chk("bubble gap data", d0, 32'h00005550);
    tick();
    chk_out("bubble b", 32'h00003C40, 32'h00003C40, 1'b0, 1'b0);

    input_valid = 1'b1;
    data_i      = 16'h7555;
    tick();
    rst         = 1'b1;
    input_valid = 1'b0;
    tick();
    chk("midrst data", d0, 32'd0);
    chk("midrst upd", {31'b0, u0}, 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst upd n2", {31'b0, u0}, 32'd0);
    tick();
    chk("midrst upd n3", {31'b0, u0}, 32'd0);

    rst         = 1'b1;
    input_valid = 1'b1;
    data_i      = 16'h7555;
    tick();
    rst         = 1'b0;
    input_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("samecyc rst upd", {31'b0, u0}, 32'd0);
    end
    chk("samecyc rst data", d0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
